// File: rtl/add.sv
// Registered DATAWIDTH-bit unsigned adder with carry-out and signed-overflow flag, one-cycle latency.
// Define ADD_SAT_EN to clamp sum to all-ones on unsigned carry-out.
module add #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic                 in_valid,
    output logic [DATAWIDTH-1:0] sum,
    output logic                 carry,
    output logic                 ovf,
    output logic                 out_valid
);

    logic [DATAWIDTH:0]   full_n;
    logic [DATAWIDTH-1:0] sum_n;
    logic                 carry_n;
    logic                 ovf_n;
    logic [DATAWIDTH-1:0] sum_sel;

    logic [DATAWIDTH-1:0] sum_d,       sum_q;
    logic                 carry_d,     carry_q;
    logic                 ovf_d,       ovf_q;
    logic                 out_valid_d, out_valid_q;

    always_comb begin
        full_n  = {1'b0, a} + {1'b0, b};
        sum_n   = full_n[DATAWIDTH-1:0];
        carry_n = full_n[DATAWIDTH];
        // Signed overflow: like-signed operands whose wrapped sum flips sign.
        ovf_n   = (a[DATAWIDTH-1] == b[DATAWIDTH-1]) && (sum_n[DATAWIDTH-1] != a[DATAWIDTH-1]);
`ifdef ADD_SAT_EN
        sum_sel = carry_n ? '1 : sum_n;
`else
        sum_sel = sum_n;
`endif
    end

    always_comb begin
        sum_d       = sum_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            sum_d   = sum_sel;
            carry_d = carry_n;
            ovf_d   = ovf_n;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sum_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_add.sv
// Scoreboard bench for add at DATAWIDTH=4, plus a DATAWIDTH=1 instance for the 1+1 corner.
module tb_add;

    typedef struct {
        logic       v;
        logic [3:0] s;
        logic       c;
        logic       o;
    } exp_t;

    logic       Clk, Rst;
    logic [3:0] a, b;
    logic       in_valid;
    logic [3:0] sum;
    logic       carry, ovf, out_valid;

    logic [0:0] a1, b1;
    logic       in_valid1;
    logic [0:0] sum1;
    logic       carry1, ovf1, out_valid1;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t m;     // last loaded result, i.e. what the DUT should be holding

    add #(.DATAWIDTH(4)) dut (
        .Clk(Clk), .Rst(Rst), .a(a), .b(b), .in_valid(in_valid),
        .sum(sum), .carry(carry), .ovf(ovf), .out_valid(out_valid)
    );

    add #(.DATAWIDTH(1)) dut1 (
        .Clk(Clk), .Rst(Rst), .a(a1), .b(b1), .in_valid(in_valid1),
        .sum(sum1), .carry(carry1), .ovf(ovf1), .out_valid(out_valid1)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Independent reference: integer arithmetic and signed range test.
    function automatic exp_t model(input int ai, input int bi, input logic v, input exp_t held);
        exp_t e;
        int   s, sa, sb, ss;
        e = held;
        e.v = v;
        if (v) begin
            s   = ai + bi;
            e.c = (s >= 16);
            e.s = 4'(s % 16);
`ifdef ADD_SAT_EN
            if (s >= 16) e.s = 4'd15;
`endif
            sa  = (ai >= 8) ? ai - 16 : ai;
            sb  = (bi >= 8) ? bi - 16 : bi;
            ss  = sa + sb;
            e.o = (ss > 7) || (ss < -8);
        end
        return e;
    endfunction

    // Directed drive with hand-computed expectation.
    task automatic drive(input int ai, input int bi, input logic v,
                         input int es, input logic ec, input logic eo);
        exp_t e;
        @(negedge Clk);
        a = 4'(ai); b = 4'(bi); in_valid = v;
        e.v = v; e.s = 4'(es); e.c = ec; e.o = eo;
        m = e;
        q.push_back(e);
    endtask

    task automatic drive_rand();
        int   ai, bi;
        logic v;
        ai = $urandom_range(0, 15);
        bi = $urandom_range(0, 15);
        v  = 1'($urandom_range(0, 1));
        @(negedge Clk);
        a = 4'(ai); b = 4'(bi); in_valid = v;
        m = model(ai, bi, v, m);
        q.push_back(m);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge Clk);
            n++;
        end
        #2;
        chk("drain_timeout", q.size(), 0);
    endtask

    // Monitor: one scoreboard entry per driven cycle, compared just after the capturing edge.
    always begin
        exp_t e;
        @(posedge Clk);
        #1;
        if (!Rst && q.size() != 0) begin
            e = q.pop_front();
            chk("out_valid", int'(out_valid), int'(e.v));
            chk("sum",       int'(sum),       int'(e.s));
            chk("carry",     int'(carry),     int'(e.c));
            chk("ovf",       int'(ovf),       int'(e.o));
        end
    end

    initial begin
        Rst = 1'b1; a = '0; b = '0; in_valid = 1'b0;
        a1 = '0; b1 = '0; in_valid1 = 1'b0;
        m = '{v: 1'b0, s: 4'd0, c: 1'b0, o: 1'b0};
        #1;
        chk("rst_sum",   int'(sum), 0);
        chk("rst_carry", int'(carry), 0);
        chk("rst_ovf",   int'(ovf), 0);
        chk("rst_vld",   int'(out_valid), 0);
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;

        drive(0, 0, 1, 0,  0, 0);
        drive(1, 1, 1, 2,  0, 0);
        drive(2, 2, 1, 4,  0, 0);
        drive(4, 4, 1, 8,  0, 1);
        drive(1, 9, 1, 10, 0, 0);
        drive(9, 1, 1, 10, 0, 0);
`ifdef ADD_SAT_EN
        drive(9, 9, 1, 15, 1, 1);
`else
        drive(9, 9, 1, 2,  1, 1);
`endif
        drive(4, 4, 1, 8,  0, 1);
`ifdef ADD_SAT_EN
        drive(15, 1, 1, 15, 1, 0);
        repeat (3) drive(3, 5, 0, 15, 1, 0);
`else
        drive(15, 1, 1, 0, 1, 0);
        repeat (3) drive(3, 5, 0, 0, 1, 0);
`endif
        drain();

        // Asynchronous reset mid-run, asserted together with a qualified operation.
        @(negedge Clk);
        #2;
        a = 4'd7; b = 4'd7; in_valid = 1'b1; Rst = 1'b1;
        #1;
        chk("arst_sum",   int'(sum), 0);
        chk("arst_carry", int'(carry), 0);
        chk("arst_ovf",   int'(ovf), 0);
        chk("arst_vld",   int'(out_valid), 0);
        @(posedge Clk);
        #1;
        chk("arst_edge_vld", int'(out_valid), 0);
        chk("arst_edge_sum", int'(sum), 0);
        @(negedge Clk);
        in_valid = 1'b0; Rst = 1'b0;
        @(posedge Clk);
        #1;
        chk("post_rst_no_pulse", int'(out_valid), 0);
        m = '{v: 1'b0, s: 4'd0, c: 1'b0, o: 1'b0};

        // First op after reset produces a normal result.
        drive(6, 3, 1, 9, 0, 1);
        drain();

        // DATAWIDTH=1 corner: 1+1.
        @(negedge Clk);
        a1 = 1'b1; b1 = 1'b1; in_valid1 = 1'b1;
        @(posedge Clk);
        #1;
        in_valid1 = 1'b0;
        chk("w1_vld",   int'(out_valid1), 1);
`ifdef ADD_SAT_EN
        chk("w1_sum",   int'(sum1), 1);
`else
        chk("w1_sum",   int'(sum1), 0);
`endif
        chk("w1_carry", int'(carry1), 1);
        chk("w1_ovf",   int'(ovf1), 1);

        repeat (1000) drive_rand();
        @(negedge Clk);
        in_valid = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/add.md
ADD -- requirements
Module: add

Interface
REQ-001: Parameter DATAWIDTH, default 8, operand and result width in bits (legal range 1..64).
REQ-002: Clk  input  1  rising-edge clock for all state.
REQ-003: Rst  input  1  reset, asynchronous and active-high.
REQ-004: a  input  DATAWIDTH  addend A, unsigned.
REQ-005: b  input  DATAWIDTH  addend B, unsigned.
REQ-006: in_valid  input  1  a/b qualify as a new operation this cycle.
REQ-007: sum  output  DATAWIDTH  registered result.
REQ-008: carry  output  1  registered carry-out of the unsigned add.
REQ-009: ovf  output  1  registered signed (two's-complement) overflow flag.
REQ-010: out_valid  output  1  sum/carry/ovf hold the result of a qualified operation.

Function
REQ-011: Full add SHALL be computed at DATAWIDTH+1 bits: {carry_n, sum_n} = a + b, with zero-extension of both operands.
REQ-012: On a rising Clk edge with in_valid=1, sum, carry and ovf SHALL load sum_n, carry_n and ovf_n; out_valid SHALL go to 1 on the same edge.
REQ-013: Latency SHALL be exactly one cycle, with no stall; one new operation is accepted per cycle.
REQ-014: On a rising Clk edge with in_valid=0, sum, carry and ovf SHALL hold their values and out_valid SHALL go to 0.
REQ-015: Wrap-around: with the saturation feature absent, sum SHALL be (a+b) mod 2^DATAWIDTH and carry SHALL be 1 exactly when a+b >= 2^DATAWIDTH.
REQ-016: ovf_n SHALL be 1 exactly when a[MSB]==b[MSB] and sum_n[MSB]!=a[MSB].
REQ-017: The block SHALL use no combinational path from inputs to outputs.
REQ-018: With DATAWIDTH=1, ovf SHALL still follow REQ-016 (1+1 gives sum 0, carry 1, ovf 1).

Reset
REQ-019: While Rst=1, sum SHALL be 0, carry 0, ovf 0 and out_valid 0, asynchronously and regardless of Clk.
REQ-020: Rst asserted in the same cycle as in_valid=1 SHALL discard the operation, so that no out_valid pulse follows.
REQ-021: After Rst deasserts, the first Clk edge with in_valid=1 SHALL produce a normal result.

Configuration
REQ-022: Macro ADD_SAT_EN SHALL select saturating behaviour when defined.
REQ-023: With ADD_SAT_EN defined and carry_n=1, sum SHALL load all-ones (2^DATAWIDTH-1); carry and ovf SHALL still report the unsaturated add per REQ-015/REQ-016.
REQ-024: With ADD_SAT_EN undefined, sum SHALL wrap as in REQ-015 and no saturation logic SHALL be present.

Verification (DATAWIDTH=4)
REQ-025: Rst=1 mid-run with in_valid=1 -> sum=0, carry=0, ovf=0, out_valid=0 immediately, without waiting for a clock edge.
REQ-026: Drive a/b = 0/0, 1/1, 2/2, 4/4, 1/9, 9/1 on consecutive cycles with in_valid=1 -> one cycle later sum = 0, 2, 4, 8, 10, 10; carry=0 throughout; out_valid=1 throughout.
REQ-027: Drive a=9, b=9 -> without ADD_SAT_EN: sum=2, carry=1, ovf=1; with ADD_SAT_EN: sum=15, carry=1, ovf=1.
REQ-028: Drive a=4, b=4 -> sum=8, carry=0, ovf=1 (signed 4+4 exceeds 7).
REQ-029: Drive a=15, b=1 with in_valid=1, then in_valid=0 for 3 cycles -> sum=0 and carry=1 held throughout; out_valid is 1 for one cycle, then 0.
REQ-030: Run 1000 random a/b/in_valid cycles -> every out_valid=1 cycle matches a reference model of REQ-011..REQ-016 (and REQ-023 when ADD_SAT_EN is defined).
